// File: rtl/mp_mem_arbiter.sv
// Round-robin arbiter that serialises per-core read/write requests onto a single
// memory port and returns one-cycle responses, turning missing read data into an error.
module mp_mem_arbiter #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8,
   parameter int CORE_ID_W  = 2,
   parameter int RD_TIMEOUT = 16
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [(1<<CORE_ID_W)-1:0]             req,
   input  logic [4*(1<<CORE_ID_W)-1:0]           opcode,
   input  logic [ADDR_WIDTH*(1<<CORE_ID_W)-1:0]  addr,
   input  logic [DATA_WIDTH*(1<<CORE_ID_W)-1:0]  wdata,
   output logic [(1<<CORE_ID_W)-1:0]             gnt,
   output logic [(1<<CORE_ID_W)-1:0]             rsp_valid,
   output logic [DATA_WIDTH-1:0]                 rsp_data,
   output logic                                  rsp_err,
   output logic                                  mem_read_en,
   output logic                                  mem_write_en,
   output logic [ADDR_WIDTH-1:0]                 mem_addr,
   output logic [DATA_WIDTH-1:0]                 mem_data_in,
   output logic [CORE_ID_W-1:0]                  mem_core_id,
   input  logic [DATA_WIDTH-1:0]                 mem_data_out,
   input  logic                                  mem_valid_out
);

   localparam int NC    = 1 << CORE_ID_W;
   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT_RD = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   localparam logic [3:0] OP_READ  = 4'h1;
   localparam logic [3:0] OP_WRITE = 4'h2;

   logic [1:0]            state;
   logic [CORE_ID_W-1:0]  owner;
   logic [CORE_ID_W-1:0]  last_grant;
   logic [3:0]            op_q;
   logic [CNT_W-1:0]      cnt;

   logic [CORE_ID_W-1:0]  pick;
   logic [CORE_ID_W-1:0]  idx;
   logic                  found;
   logic [NC-1:0]         pick_oh;
   logic [NC-1:0]         owner_oh;
   logic [3:0]            sel_op;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   // Scan from last_grant+1 with wrap; last_grant itself is visited last.
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= NC; i++) begin
         idx = last_grant + CORE_ID_W'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      pick_oh        = '0;
      pick_oh[pick]  = 1'b1;
      owner_oh       = '0;
      owner_oh[owner] = 1'b1;
      sel_op   = opcode[int'(pick)*4 +: 4];
      sel_addr = addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
      sel_data = wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
   end

   // Memory strobes are launched on the arbitration edge so they appear in ISSUE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         owner        <= '0;
         last_grant   <= '1;
         op_q         <= '0;
         cnt          <= '0;
         gnt          <= '0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         mem_addr     <= '0;
         mem_data_in  <= '0;
         mem_core_id  <= '0;
      end else begin
         gnt          <= '0;
         rsp_valid    <= '0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         mem_addr     <= '0;
         mem_data_in  <= '0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  owner       <= pick;
                  op_q        <= sel_op;
                  gnt         <= pick_oh;
                  mem_core_id <= pick;
                  if (sel_op == OP_READ) begin
                     mem_read_en <= 1'b1;
                     mem_addr    <= sel_addr;
                  end else if (sel_op == OP_WRITE) begin
                     mem_write_en <= 1'b1;
                     mem_addr     <= sel_addr;
                     mem_data_in  <= sel_data;
                  end
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               last_grant <= owner;
               cnt        <= '0;
               if (op_q == OP_READ) begin
                  state <= S_WAIT_RD;
               end else begin
                  rsp_valid <= owner_oh;
                  rsp_err   <= (op_q != OP_WRITE);
                  rsp_data  <= (op_q == OP_WRITE) ? '0 : '1;
                  state     <= S_RESP;
               end
            end
            S_WAIT_RD: begin
               cnt <= cnt + 1'b1;
               if (mem_valid_out) begin
                  rsp_valid <= owner_oh;
                  rsp_data  <= mem_data_out;
                  rsp_err   <= 1'b0;
                  state     <= S_RESP;
               end else if (cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                  rsp_valid <= owner_oh;
                  rsp_data  <= '1;
                  rsp_err   <= 1'b1;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               rsp_data    <= '0;
               rsp_err     <= 1'b0;
               mem_core_id <= '0;
               cnt         <= '0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mp_mem_arbiter.sv
// Directed bench for mp_mem_arbiter: reset, write, read, fairness, timeout and
// illegal-opcode sequences with hand-computed expectations.
module tb_mp_mem_arbiter;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req;
   logic [15:0] opcode;
   logic [43:0] addr;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [10:0] mem_addr;
   logic [7:0]  mem_data_in;
   logic [1:0]  mem_core_id;
   logic [7:0]  mem_data_out;
   logic        mem_valid_out;

   int checks = 0;
   int errors = 0;

   mp_mem_arbiter #(
      .ADDR_WIDTH (11),
      .DATA_WIDTH (8),
      .CORE_ID_W  (2),
      .RD_TIMEOUT (16)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req           (req),
      .opcode        (opcode),
      .addr          (addr),
      .wdata         (wdata),
      .gnt           (gnt),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .mem_read_en   (mem_read_en),
      .mem_write_en  (mem_write_en),
      .mem_addr      (mem_addr),
      .mem_data_in   (mem_data_in),
      .mem_core_id   (mem_core_id),
      .mem_data_out  (mem_data_out),
      .mem_valid_out (mem_valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_gnt"},   {28'd0, gnt},         32'h0);
      check({tag, "_rspv"},  {28'd0, rsp_valid},   32'h0);
      check({tag, "_rspd"},  {24'd0, rsp_data},    32'h0);
      check({tag, "_rspe"},  {31'd0, rsp_err},     32'h0);
      check({tag, "_rd"},    {31'd0, mem_read_en}, 32'h0);
      check({tag, "_wr"},    {31'd0, mem_write_en}, 32'h0);
      check({tag, "_maddr"}, {21'd0, mem_addr},    32'h0);
      check({tag, "_mdin"},  {24'd0, mem_data_in}, 32'h0);
      check({tag, "_mcid"},  {30'd0, mem_core_id}, 32'h0);
   endtask

   task automatic set_req(input int core, input logic [3:0] op, input logic [10:0] a,
                          input logic [7:0] d);
      req[core]             = 1'b1;
      opcode[core*4 +: 4]   = op;
      addr[core*11 +: 11]   = a;
      wdata[core*8 +: 8]    = d;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic wait_gnt(input string tag, input logic [3:0] exp);
      int unsigned n = 0;
      do begin
         tick();
         n++;
      end while (gnt == 4'b0 && n < 20);
      check(tag, {28'd0, gnt}, {28'd0, exp});
   endtask

   initial begin
      int unsigned n;
      reset_n       = 1'b0;
      req           = '0;
      opcode        = '0;
      addr          = '0;
      wdata         = '0;
      mem_data_out  = '0;
      mem_valid_out = 1'b0;

      // 1: reset state, idle, reset during WAIT_RD
      tick();
      tick();
      check_idle("rst");
      reset_n = 1'b1;
      tick();
      tick();
      check_idle("idle");

      set_req(1, 4'h1, 11'h010, 8'h00);
      tick();
      check("t1_gnt", {28'd0, gnt}, 32'h2);
      check("t1_rd", {31'd0, mem_read_en}, 32'h1);
      tick();
      check("t1_wait_cid", {30'd0, mem_core_id}, 32'h1);
      reset_n = 1'b0;
      #1;
      check_idle("t1_midrst");
      tick();
      reset_n = 1'b1;
      tick();
      check("t1_regnt", {28'd0, gnt}, 32'h2);
      check("t1_nostale", {28'd0, rsp_valid}, 32'h0);
      req = '0;
      tick();
      check("t1_wait_rspv", {28'd0, rsp_valid}, 32'h0);
      mem_valid_out = 1'b1;
      mem_data_out  = 8'h55;
      tick();
      mem_valid_out = 1'b0;
      mem_data_out  = 8'h00;
      check("t1_lat1_rspv", {28'd0, rsp_valid}, 32'h2);
      check("t1_lat1_rspd", {24'd0, rsp_data}, 32'h55);
      tick();
      check_idle("t1_end");

      // 2: core 2 write
      set_req(2, 4'h2, 11'h123, 8'hA5);
      tick();
      check("t2_gnt",  {28'd0, gnt},          32'h4);
      check("t2_wr",   {31'd0, mem_write_en}, 32'h1);
      check("t2_rd",   {31'd0, mem_read_en},  32'h0);
      check("t2_addr", {21'd0, mem_addr},     32'h123);
      check("t2_din",  {24'd0, mem_data_in},  32'hA5);
      check("t2_cid",  {30'd0, mem_core_id},  32'h2);
      req = '0;
      tick();
      check("t2_rspv", {28'd0, rsp_valid},    32'h4);
      check("t2_rspe", {31'd0, rsp_err},      32'h0);
      check("t2_rspd", {24'd0, rsp_data},     32'h0);
      check("t2_wr_off", {31'd0, mem_write_en}, 32'h0);
      check("t2_addr_off", {21'd0, mem_addr}, 32'h0);
      tick();
      check_idle("t2_end");

      // 3: core 1 read, data two cycles after ISSUE
      set_req(1, 4'h1, 11'h7FF, 8'h00);
      tick();
      check("t3_gnt",  {28'd0, gnt},         32'h2);
      check("t3_rd",   {31'd0, mem_read_en}, 32'h1);
      check("t3_wr",   {31'd0, mem_write_en}, 32'h0);
      check("t3_addr", {21'd0, mem_addr},    32'h7FF);
      check("t3_din",  {24'd0, mem_data_in}, 32'h0);
      req = '0;
      tick();
      check("t3_w1_rd",   {31'd0, mem_read_en}, 32'h0);
      check("t3_w1_addr", {21'd0, mem_addr},    32'h0);
      check("t3_w1_cid",  {30'd0, mem_core_id}, 32'h1);
      check("t3_w1_rspv", {28'd0, rsp_valid},   32'h0);
      tick();
      check("t3_w2_rspv", {28'd0, rsp_valid},   32'h0);
      mem_valid_out = 1'b1;
      mem_data_out  = 8'h3C;
      tick();
      mem_valid_out = 1'b0;
      mem_data_out  = 8'h00;
      check("t3_rspv", {28'd0, rsp_valid}, 32'h2);
      check("t3_rspd", {24'd0, rsp_data},  32'h3C);
      check("t3_rspe", {31'd0, rsp_err},   32'h0);
      tick();
      check_idle("t3_end");

      // 4: fairness with all four cores, then cores 0 and 3 only
      do_reset();
      set_req(0, 4'h2, 11'h001, 8'h10);
      set_req(1, 4'h2, 11'h002, 8'h11);
      set_req(2, 4'h2, 11'h003, 8'h12);
      set_req(3, 4'h2, 11'h004, 8'h13);
      wait_gnt("t4_g0", 4'b0001);
      wait_gnt("t4_g1", 4'b0010);
      check("t4_g1_addr", {21'd0, mem_addr}, 32'h002);
      wait_gnt("t4_g2", 4'b0100);
      wait_gnt("t4_g3", 4'b1000);
      check("t4_g3_cid", {30'd0, mem_core_id}, 32'h3);
      wait_gnt("t4_g4", 4'b0001);
      req = '0;
      tick();
      tick();
      do_reset();
      set_req(0, 4'h2, 11'h001, 8'h10);
      set_req(3, 4'h2, 11'h004, 8'h13);
      wait_gnt("t4_p0", 4'b0001);
      wait_gnt("t4_p1", 4'b1000);
      wait_gnt("t4_p2", 4'b0001);
      wait_gnt("t4_p3", 4'b1000);
      req = '0;
      tick();
      tick();
      check_idle("t4_end");

      // 5: core 3 read timeout with core 0 pending
      set_req(3, 4'h1, 11'h456, 8'h00);
      tick();
      check("t5_gnt", {28'd0, gnt}, 32'h8);
      req = '0;
      set_req(0, 4'h2, 11'h0AA, 8'h5A);
      n = 0;
      tick();
      while (rsp_valid == 4'b0 && n < 40) begin
         n++;
         tick();
      end
      check("t5_wait_cycles", n, 32'd16);
      check("t5_rspv", {28'd0, rsp_valid}, 32'h8);
      check("t5_rspe", {31'd0, rsp_err},   32'h1);
      check("t5_rspd", {24'd0, rsp_data},  32'hFF);
      tick();
      check("t5_idle_gnt", {28'd0, gnt}, 32'h0);
      tick();
      check("t5_next_gnt", {28'd0, gnt}, 32'h1);
      req = '0;
      tick();
      check("t5_next_rspv", {28'd0, rsp_valid}, 32'h1);
      tick();
      check_idle("t5_end");

      // 6: illegal opcode, then stray valid in IDLE
      set_req(0, 4'h7, 11'h055, 8'h11);
      tick();
      check("t6_gnt",  {28'd0, gnt},          32'h1);
      check("t6_rd",   {31'd0, mem_read_en},  32'h0);
      check("t6_wr",   {31'd0, mem_write_en}, 32'h0);
      check("t6_addr", {21'd0, mem_addr},     32'h0);
      req = '0;
      tick();
      check("t6_rspv", {28'd0, rsp_valid}, 32'h1);
      check("t6_rspe", {31'd0, rsp_err},   32'h1);
      check("t6_rspd", {24'd0, rsp_data},  32'hFF);
      tick();
      check_idle("t6_idle");
      mem_valid_out = 1'b1;
      mem_data_out  = 8'h77;
      tick();
      mem_valid_out = 1'b0;
      mem_data_out  = 8'h00;
      check("t6_stray_rspv", {28'd0, rsp_valid}, 32'h0);
      tick();
      check("t6_stray_rspv2", {28'd0, rsp_valid}, 32'h0);
      check("t6_stray_rspe",  {31'd0, rsp_err},   32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mp_mem_arbiter.md
Name: mp_mem_arbiter

Overview:
Round-robin request arbiter and transaction sequencer placed directly upstream of the shared memory in the multiprocessor system. It accepts read/write requests from 4 cores and serialises them onto the memory's single port (read_en/write_en/addr/data_in, tagged with core_id). It then routes the memory's data_out/valid_out back to the requesting core as a one-cycle response, and converts missing read data into a timeout error.

Parameters:
ADDR_WIDTH, 11, memory address width
DATA_WIDTH, 8, memory data width
CORE_ID_W, 2, core index width; number of cores = 2**CORE_ID_W = 4
RD_TIMEOUT, 16, cycles spent in WAIT_RD without mem_valid_out before an error response

Ports:
clk  in  1  system clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
req  in  4  per-core request, level; held until that core's gnt
opcode  in  16  per-core opcode, 4 bits each, core i at [4i+3:4i]; 4'h1=READ, 4'h2=WRITE, others illegal
addr  in  44  per-core address, ADDR_WIDTH each, packed as opcode
wdata  in  32  per-core write data, DATA_WIDTH each, packed as opcode
gnt  out  4  one-hot grant, one cycle, coincident with the memory access cycle
rsp_valid  out  4  one-hot response strobe, one cycle
rsp_data  out  8  read data; valid while rsp_valid is nonzero
rsp_err  out  1  error flag (illegal opcode or read timeout); valid with rsp_valid
mem_read_en  out  1  memory read strobe
mem_write_en  out  1  memory write strobe
mem_addr  out  11  memory address
mem_data_in  out  8  memory write data
mem_core_id  out  2  index of the owning core
mem_data_out  in  8  memory read data
mem_valid_out  in  1  memory read-data valid

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all outputs 0; state IDLE; last_grant=3, so core 0 wins first; timeout counter 0.
  - Reset mid-transaction drops the transaction; no response is issued.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP. All outputs are registered.
- IDLE:
  - If req!=0, select the first set bit scanning from (last_grant+1) mod 4 upward with wrap.
  - Capture owner, opcode, addr, wdata; go to ISSUE.
  - If req==0, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt[owner]=1 and mem_core_id=owner; last_grant<=owner.
  - READ: mem_read_en=1, mem_addr=addr; next WAIT_RD.
  - WRITE: mem_write_en=1, mem_addr=addr, mem_data_in=wdata; next RESP with err=0, rsp_data=0.
  - Illegal opcode: no memory strobe; next RESP with err=1, rsp_data=8'hFF.
- WAIT_RD:
  - mem_core_id is held and the counter increments each cycle.
  - mem_valid_out=1 captures mem_data_out; next RESP with err=0.
  - mem_valid_out is honoured even in the first WAIT_RD cycle (minimum read latency 1).
  - Counter reaching RD_TIMEOUT without valid: next RESP with err=1, rsp_data=8'hFF.
- RESP (exactly 1 cycle): rsp_valid[owner]=1 with rsp_data and rsp_err; next IDLE; counter cleared.
- Strobe rules:
  - mem_read_en and mem_write_en are never both 1.
  - mem_addr/mem_data_in are 0 whenever no strobe is active.
  - gnt and rsp_valid are 0 outside ISSUE and RESP respectively.
- mem_valid_out outside WAIT_RD is ignored and raises no error.
- Throughput:
  - Write or illegal transaction: 3 cycles (IDLE→ISSUE→RESP).
  - Read: 3 cycles + memory latency.
  - A new request is arbitrated only in IDLE, so at most one transaction is outstanding.
- Fairness: a core that keeps req high after its grant is lowest priority at the next arbitration; a core waits at most 3 other transactions.
- Request fields are sampled only at the IDLE arbitration edge; changes after that have no effect.

Test Plan:
1. Reset, then idle: all outputs 0. Assert reset_n=0 during WAIT_RD → outputs 0 immediately. After release, req[1] alone → gnt[1], with no stale response.
2. Core 2 WRITE, addr 11'h123, wdata 8'hA5 → ISSUE cycle shows gnt=4'b0100, mem_write_en=1, mem_addr=11'h123, mem_data_in=8'hA5, mem_core_id=2. Next cycle rsp_valid=4'b0100, rsp_err=0.
3. Core 1 READ, addr 11'h7FF; memory drives mem_valid_out with 8'h3C two cycles after ISSUE → rsp_valid=4'b0010, rsp_data=8'h3C, rsp_err=0, one cycle after valid.
4. All four cores request WRITE continuously from reset → grant order 0,1,2,3,0. Then only req[0] and req[3] held → order 0,3,0,3.
5. Core 3 READ with mem_valid_out held low → exactly RD_TIMEOUT=16 WAIT_RD cycles, then rsp_valid=4'b1000, rsp_err=1, rsp_data=8'hFF. A pending req[0] is granted 2 cycles later.
6. Core 0 opcode 4'h7 → gnt[0] pulses with mem_read_en=mem_write_en=0, then rsp_valid[0]=1, rsp_err=1. A stray mem_valid_out pulse in IDLE produces no response.
